// File: rtl/serial_fetch_port.sv
// Bit-serial fetch engine: shifts an address out MSB-first,
// then shifts the returned word in MSB-first and pulses valid.
module serial_fetch_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  flush,
  input  logic                  data_in,
  output logic                  addr_stream,
  output logic                  busy,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            phase
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ?
                        ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MAXW + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ash_q, ash_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH:0]   rx_cat;
  logic [DATA_WIDTH-1:0] rx_next;

  // New bit enters at the LSB so the first bit ends up as the MSB.
  assign rx_cat  = {rx_q, data_in};
  assign rx_next = rx_cat[DATA_WIDTH-1:0];

  // State, counter and shift registers; reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ash_q   <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ash_q   <= ash_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and datapath; flush overrides everything, start included.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ash_d   = ash_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ash_d   = '0;
      rx_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SEND;
            ash_d   = addr;
            cnt_d   = '0;
            rx_d    = '0;
          end
        end
        SEND: begin
          ash_d = ash_q << 1;
          if (cnt_q == A_LAST) begin
            state_d = RECV;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RECV: begin
          rx_d = rx_next;
          if (cnt_q == D_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            dout_d  = rx_next;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign addr_stream = (state_q == SEND) & ash_q[ADDR_WIDTH-1];
  assign busy        = (state_q != IDLE);
  assign data_valid  = (state_q == DONE);
  assign data_out    = dout_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_serial_fetch_port.sv
// Bench for serial_fetch_port: macro (8/32) and micro (9/44)
// instances, with a bench-side memory and expected-word scoreboard.
module tb_serial_fetch_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, flush_a, din_a;
  logic [7:0]  addr_a;
  logic        as_a, busy_a, dv_a;
  logic [31:0] dout_a;
  logic [1:0]  ph_a;
  logic        start_b, flush_b, din_b;
  logic [8:0]  addr_b;
  logic        as_b, busy_b, dv_b;
  logic [43:0] dout_b;
  logic [1:0]  ph_b;

  int errors = 0;
  int checks = 0;

  logic        abits[$];
  logic        dbits[$];
  logic [63:0] exp_q[$];

  always #5 clock = ~clock;

  serial_fetch_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .addr(addr_a),
    .flush(flush_a), .data_in(din_a), .addr_stream(as_a),
    .busy(busy_a), .data_valid(dv_a), .data_out(dout_a),
    .phase(ph_a)
  );

  serial_fetch_port #(.ADDR_WIDTH(9), .DATA_WIDTH(44)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .addr(addr_b),
    .flush(flush_b), .data_in(din_b), .addr_stream(as_b),
    .busy(busy_b), .data_valid(dv_b), .data_out(dout_b),
    .phase(ph_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] ph(input int sel);
    return (sel != 0) ? ph_b : ph_a;
  endfunction

  function automatic logic as_o(input int sel);
    return (sel != 0) ? as_b : as_a;
  endfunction

  function automatic logic dv_o(input int sel);
    return (sel != 0) ? dv_b : dv_a;
  endfunction

  function automatic logic [63:0] dout_o(input int sel);
    return (sel != 0) ? {20'd0, dout_b} : {32'd0, dout_a};
  endfunction

  task automatic drv(input int sel, input logic s,
                     input logic [63:0] a);
    if (sel != 0) begin
      start_b = s;
      addr_b  = a[8:0];
    end else begin
      start_a = s;
      addr_a  = a[7:0];
    end
  endtask

  task automatic ddin(input int sel, input logic b);
    if (sel != 0) din_b = b;
    else din_a = b;
  endtask

  // One complete fetch; ign_at >= 0 pulses start (addr all ones)
  // during that RECV bit, which must have no effect.
  task automatic fetch(input int sel, input logic [63:0] a,
                       input logic [63:0] w, input int aw,
                       input int dw, input int lat,
                       input int ign_at, input string nm);
    int  n;
    int  rxi;
    bit  got;
    logic e;
    logic [63:0] ew;
    abits.delete();
    dbits.delete();
    for (int i = aw - 1; i >= 0; i--) abits.push_back(a[i]);
    for (int i = dw - 1; i >= 0; i--) dbits.push_back(w[i]);
    exp_q.push_back(w);
    drv(sel, 1'b1, a);
    tick();
    drv(sel, 1'b0, a);
    n   = 1;
    rxi = 0;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (ph(sel) == 2'd1) begin
        e = (abits.size() != 0) ? abits.pop_front() : 1'bx;
        checks++;
        if (as_o(sel) !== e) begin
          errors++;
          $display("FAIL %s addr_stream bit: got %b want %b",
                   nm, as_o(sel), e);
        end
      end
      if (ph(sel) == 2'd2) begin
        ddin(sel, (dbits.size() != 0) ? dbits.pop_front() : 1'b0);
        if (rxi == ign_at) drv(sel, 1'b1, 64'hFFFF);
        else drv(sel, 1'b0, a);
        rxi++;
      end
      if (dv_o(sel) === 1'b1) begin
        got = 1;
        checks++;
        if (n != lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
        end
        ew = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if (dout_o(sel) !== ew) begin
          errors++;
          $display("FAIL %s data_out: got %h want %h",
                   nm, dout_o(sel), ew);
        end
      end else begin
        tick();
        n++;
      end
    end
    drv(sel, 1'b0, a);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no data_valid within budget", nm);
    end
    checks++;
    if (abits.size() != 0) begin
      errors++;
      $display("FAIL %s addr bits left: got %0d want 0",
               nm, abits.size());
    end
    tick();
    checks++;
    if (ph(sel) !== 2'd0 || dv_o(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: phase %0d dv %b want 0 0",
               nm, ph(sel), dv_o(sel));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_a = 1'b1; start_b = 1'b1;
    addr_a = 8'hA5; addr_b = 9'h13A;
    din_a = 1'b1; din_b = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0;
    tick();
    tick();
    checks++;
    if ({ph_a, busy_a, dv_a, as_a} !== 5'd0 || dout_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_a: ph %0d busy %b dv %b as %b dout %h want 0",
               ph_a, busy_a, dv_a, as_a, dout_a);
    end
    checks++;
    if ({ph_b, busy_b, dv_b, as_b} !== 5'd0 || dout_b !== 44'd0) begin
      errors++;
      $display("FAIL reset_b: ph %0d busy %b dv %b as %b dout %h want 0",
               ph_b, busy_b, dv_b, as_b, dout_b);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ph_a !== 2'd1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_a: phase %0d busy %b want 1 1",
               ph_a, busy_a);
    end
    checks++;
    if (ph_b !== 2'd1) begin
      errors++;
      $display("FAIL reset_release_b: phase %0d want 1", ph_b);
    end
    start_a = 1'b0; start_b = 1'b0;
    flush_a = 1'b1; flush_b = 1'b1;
    tick();
    flush_a = 1'b0; flush_b = 1'b0;
    checks++;
    if (ph_a !== 2'd0 || ph_b !== 2'd0) begin
      errors++;
      $display("FAIL flush_send: phase %0d/%0d want 0/0", ph_a, ph_b);
    end
  endtask

  task automatic test_basic();
    fetch(0, 64'hA5, 64'hDEADBEEF, 8, 32, 41, -1, "basic");
  endtask

  task automatic test_micro();
    fetch(1, 64'h13A, 64'hF00DCAFE123, 9, 44, 54, -1, "micro");
  endtask

  task automatic test_ignored_start();
    fetch(0, 64'h3C, 64'h13572468, 8, 32, 41, 5, "ign_start");
  endtask

  task automatic test_flush();
    logic [31:0] w = 32'h12345678;
    bit saw;
    flush_a = 1'b1;
    start_a = 1'b1;
    addr_a  = 8'hA5;
    tick();
    flush_a = 1'b0;
    start_a = 1'b0;
    checks++;
    if (ph_a !== 2'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_start: phase %0d busy %b want 0 0",
               ph_a, busy_a);
    end
    start_a = 1'b1;
    addr_a  = 8'h5A;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 20 && ph_a != 2'd2; c++) tick();
    checks++;
    if (ph_a !== 2'd2) begin
      errors++;
      $display("FAIL flush_reach_recv: phase %0d want 2", ph_a);
    end
    for (int i = 0; i < 10; i++) begin
      din_a = w[31-i];
      tick();
    end
    flush_a = 1'b1;
    din_a = w[21];
    tick();
    flush_a = 1'b0;
    checks++;
    if (ph_a !== 2'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_recv: phase %0d busy %b want 0 0",
               ph_a, busy_a);
    end
    saw = 0;
    for (int c = 0; c < 50; c++) begin
      din_a = c[0];
      if (dv_a === 1'b1) saw = 1;
      tick();
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL flush_no_valid: data_valid seen, want none");
    end
    checks++;
    if (dout_a !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL flush_dout: got %h want deadbeef", dout_a);
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    addr_a  = 8'hC3;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ph_a !== 2'd1 || as_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre: phase %0d as %b want 1 0", ph_a, as_a);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ph_a !== 2'd0 || as_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: phase %0d as %b busy %b want 0 0 0",
               ph_a, as_a, busy_a);
    end
    checks++;
    if (dout_a !== 32'd0 || dout_b !== 44'd0) begin
      errors++;
      $display("FAIL areset_dout: got %h/%h want 0/0", dout_a, dout_b);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    checks++;
    if (ph_a !== 2'd0) begin
      errors++;
      $display("FAIL areset_idle: phase %0d want 0", ph_a);
    end
    fetch(0, 64'h01, 64'hA5A55A5A, 8, 32, 41, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1 = 32'h11112222;
    logic [31:0] w2 = 32'h80000001;
    logic [7:0]  a2 = 8'h01;
    int n, pulses, t1, t2;
    logic e;
    logic [63:0] ew;
    abits.delete();
    dbits.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) abits.push_back(1'b0);
    for (int i = 7; i >= 0; i--) abits.push_back(a2[i]);
    for (int i = 31; i >= 0; i--) dbits.push_back(w1[i]);
    for (int i = 31; i >= 0; i--) dbits.push_back(w2[i]);
    exp_q.push_back({32'd0, w1});
    exp_q.push_back({32'd0, w2});
    start_a = 1'b1;
    addr_a  = 8'h00;
    tick();
    addr_a = a2;
    n = 1;
    pulses = 0;
    t1 = 0;
    t2 = 0;
    for (int c = 0; c < 150 && pulses < 2; c++) begin
      if (ph_a == 2'd1) begin
        e = (abits.size() != 0) ? abits.pop_front() : 1'bx;
        checks++;
        if (as_a !== e) begin
          errors++;
          $display("FAIL b2b addr_stream: got %b want %b", as_a, e);
        end
      end
      if (ph_a == 2'd2)
        din_a = (dbits.size() != 0) ? dbits.pop_front() : 1'b0;
      if (dv_a === 1'b1) begin
        pulses++;
        if (pulses == 1) t1 = n;
        else t2 = n;
        ew = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({32'd0, dout_a} !== ew) begin
          errors++;
          $display("FAIL b2b data_out: got %h want %h", dout_a, ew);
        end
      end
      if (pulses < 2) begin
        tick();
        n++;
      end
    end
    start_a = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b pulses: got %0d want 2", pulses);
    end
    checks++;
    if (t1 != 41 || t2 - t1 != 42) begin
      errors++;
      $display("FAIL b2b spacing: first %0d gap %0d want 41 42",
               t1, t2 - t1);
    end
    checks++;
    if (abits.size() != 0) begin
      errors++;
      $display("FAIL b2b addr bits left: got %0d want 0", abits.size());
    end
    tick();
    tick();
    checks++;
    if (ph_a !== 2'd0) begin
      errors++;
      $display("FAIL b2b final phase: got %0d want 0", ph_a);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_start();
    test_basic();
    test_micro();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
